// File: rtl/ucsbece154b_perf_pkg.sv
// ucsbece154b_perf_pkg
// Shared definitions for the performance monitor: FSM state encoding,
// read-select codes, the canonical NOP encoding, RISC-V control-transfer
// opcodes and a small population-count helper used to turn per-lane
// event masks into per-cycle counter increments.
package ucsbece154b_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } perfState_t;

  localparam logic [2:0] SEL_CYC  = 3'd0;
  localparam logic [2:0] SEL_INS  = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_BRM  = 3'd3;
  localparam logic [2:0] SEL_JMP  = 3'd4;
  localparam logic [2:0] SEL_JMPM = 3'd5;
  localparam logic [2:0] SEL_INS0 = 3'd6;
  localparam logic [2:0] SEL_ZERO = 3'd7;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Masks are always 4 bits wide (max issue width); unused lanes are zero.
  function automatic logic [2:0] popcount4(input logic [3:0] bits);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// ucsbece154b_sat_counter
// Saturating up-counter with a small per-cycle increment.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset to zero
//   clr    synchronous clear to zero (same effect as reset)
//   en     when high, add inc this cycle
//   inc    increment amount (0..7)
//   q      current count; sticks at all-ones instead of wrapping
module ucsbece154b_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [2:0]   inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;

  // One extra bit catches the carry out; a carry means the true sum is
  // past the maximum, so the counter pins at all-ones.
  assign w_sum = {1'b0, r_count} + {{(W-2){1'b0}}, inc};

  // Clear wins over counting so events in a reset/clear cycle are dropped.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end

  assign q = r_count;

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// ucsbece154b_perf_monitor
// Performance monitor for the N-wide superscalar pipeline. Counts cycles,
// useful decoded instructions, branches, branch mispredicts, jumps and
// jumps that were not predicted taken across every issue lane, and detects
// program completion (all fetch lanes parked on a NOP at an unchanging PC).
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear_i           synchronous clear of counters and FSM (not rdata_o)
//   enable_i          counting enable; also starts IDLE -> RUN
//   validD_i/instrD_i per-lane decode valid and instruction
//   validE_i/opE_i    per-lane execute valid and opcode
//   mispredictE_i     per-lane branch mispredict in execute
//   predtakenE_i      per-lane predicted-taken flag from fetch
//   pcF_i/instrF_i    per-lane fetch PC and instruction
//   sel_i             counter select for the read port
//   rdata_o           selected counter, registered (1-cycle latency)
//   halted_o          FSM is in HALTED
//   timeout_o         FSM is in TIMEOUT
//   state_o           raw FSM state encoding
module ucsbece154b_perf_monitor
  import ucsbece154b_perf_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int CNT_W       = 32,
  parameter int HALT_CYCLES = 2,
  parameter int MAX_CYCLES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [LANES-1:0]      validD_i,
  input  logic [LANES*32-1:0]   instrD_i,
  input  logic [LANES-1:0]      validE_i,
  input  logic [LANES*7-1:0]    opE_i,
  input  logic [LANES-1:0]      mispredictE_i,
  input  logic [LANES-1:0]      predtakenE_i,
  input  logic [LANES*32-1:0]   pcF_i,
  input  logic [LANES*32-1:0]   instrF_i,
  input  logic [2:0]            sel_i,
  output logic [CNT_W-1:0]      rdata_o,
  output logic                  halted_o,
  output logic                  timeout_o,
  output logic [1:0]            state_o
);

  localparam int STREAK_W = (HALT_CYCLES <= 1) ? 1 : $clog2(HALT_CYCLES + 1);

  perfState_t            r_state;
  logic                  r_halted;
  logic                  r_timeout;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_prevValid;
  logic [LANES*32-1:0]   r_pcPrev;
  logic [CNT_W-1:0]      r_rdata;

  logic [3:0]            w_insMask;
  logic [3:0]            w_brMask;
  logic [3:0]            w_brmMask;
  logic [3:0]            w_jmpMask;
  logic [3:0]            w_jmpmMask;
  logic [3:0]            w_idleMask;
  logic                  w_count;
  logic                  w_allIdle;
  logic [STREAK_W-1:0]   w_streakInc;
  logic                  w_haltHit;
  logic                  w_timeoutHit;
  logic [CNT_W-1:0]      w_rdataNext;

  logic [CNT_W-1:0]      w_cyc;
  logic [CNT_W-1:0]      w_ins;
  logic [CNT_W-1:0]      w_br;
  logic [CNT_W-1:0]      w_brm;
  logic [CNT_W-1:0]      w_jmp;
  logic [CNT_W-1:0]      w_jmpm;
  logic [CNT_W-1:0]      w_ins0;

  // Per-lane event classification. Masks are padded to four lanes; the
  // idle mask pads with ones so unused lanes never block halt detection.
  // A fetch lane is idle only once a previous-cycle PC exists to compare to.
  always_comb begin
    w_insMask  = '0;
    w_brMask   = '0;
    w_brmMask  = '0;
    w_jmpMask  = '0;
    w_jmpmMask = '0;
    w_idleMask = '1;
    for (int k = 0; k < LANES; k++) begin
      w_insMask[k]  = validD_i[k]
                      && (instrD_i[32*k +: 32] != 32'h0000_0000)
                      && (instrD_i[32*k +: 32] != NOP);
      w_brMask[k]   = validE_i[k] && (opE_i[7*k +: 7] == OP_BRANCH);
      w_brmMask[k]  = w_brMask[k] && mispredictE_i[k];
      w_jmpMask[k]  = validE_i[k]
                      && ((opE_i[7*k +: 7] == OP_JAL) || (opE_i[7*k +: 7] == OP_JALR));
      w_jmpmMask[k] = w_jmpMask[k] && !predtakenE_i[k];
      w_idleMask[k] = r_prevValid
                      && (instrF_i[32*k +: 32] == NOP)
                      && (pcF_i[32*k +: 32] == r_pcPrev[32*k +: 32]);
    end
  end

  assign w_count   = (r_state == ST_RUN) && enable_i;
  assign w_allIdle = &w_idleMask;

  // Streak value if this cycle is idle; it saturates at the halt threshold.
  assign w_streakInc = (r_streak >= STREAK_W'(HALT_CYCLES)) ? r_streak
                                                           : r_streak + STREAK_W'(1);

  // Halt is declared on the same edge the streak reaches the threshold, so
  // the detecting cycle is still counted.
  assign w_haltHit = w_count && w_allIdle && (w_streakInc == STREAK_W'(HALT_CYCLES));

  // Timeout fires on the edge where the cycle counter becomes MAX_CYCLES.
  assign w_timeoutHit = (MAX_CYCLES != 0) && w_count
                        && (({1'b0, w_cyc} + (CNT_W+1)'(1)) >= (CNT_W+1)'(MAX_CYCLES));

  // Control FSM plus halt-detection state. clear_i behaves exactly like
  // reset here. HALTED takes priority over TIMEOUT when both hit together;
  // both terminal states are sticky.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      r_state     <= ST_IDLE;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_streak    <= '0;
      r_prevValid <= 1'b0;
      r_pcPrev    <= '0;
    end else begin
      r_pcPrev <= pcF_i;
      if (r_state == ST_RUN) begin
        r_prevValid <= 1'b1;
      end
      if (w_count && w_allIdle) begin
        r_streak <= w_streakInc;
      end else if (!enable_i || !w_allIdle) begin
        r_streak <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_haltHit) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (w_timeoutHit) begin
            r_state   <= ST_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntCyc (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc(3'd1), .q(w_cyc)
  );

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntIns (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc(popcount4(w_insMask)), .q(w_ins)
  );

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntBr (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc(popcount4(w_brMask)), .q(w_br)
  );

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntBrm (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc(popcount4(w_brmMask)), .q(w_brm)
  );

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntJmp (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc(popcount4(w_jmpMask)), .q(w_jmp)
  );

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntJmpm (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc(popcount4(w_jmpmMask)), .q(w_jmpm)
  );

  ucsbece154b_sat_counter #(.W(CNT_W)) u_cntIns0 (
    .clk(clk), .reset(reset), .clr(clear_i), .en(w_count),
    .inc({2'b00, w_insMask[0]}), .q(w_ins0)
  );

  // Read-port select.
  always_comb begin
    w_rdataNext = '0;
    case (sel_i)
      SEL_CYC:  w_rdataNext = w_cyc;
      SEL_INS:  w_rdataNext = w_ins;
      SEL_BR:   w_rdataNext = w_br;
      SEL_BRM:  w_rdataNext = w_brm;
      SEL_JMP:  w_rdataNext = w_jmp;
      SEL_JMPM: w_rdataNext = w_jmpm;
      SEL_INS0: w_rdataNext = w_ins0;
      SEL_ZERO: w_rdataNext = '0;
      default:  w_rdataNext = '0;
    endcase
  end

  // The read register ignores clear_i so software can still sample the
  // pre-clear value on the clearing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdataNext;
    end
  end

  assign rdata_o   = r_rdata;
  assign halted_o  = r_halted;
  assign timeout_o = r_timeout;
  assign state_o   = r_state;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// tb_ucsbece154b_perf_monitor
// Directed bench for the performance monitor. Three instances share the
// same stimulus: a default configuration, an 8-bit counter build for
// saturation, and a MAX_CYCLES=5 build for the timeout path.
module tb_ucsbece154b_perf_monitor;

  localparam logic [31:0] ADDI = 32'h0050_0293;
  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [6:0]  OPB  = 7'b1100011;
  localparam logic [6:0]  OPJ  = 7'b1101111;
  localparam logic [6:0]  OPJR = 7'b1100111;

  logic        clk;
  logic        reset;
  logic        clear_i;
  logic        enable_i;
  logic [1:0]  validD_i;
  logic [63:0] instrD_i;
  logic [1:0]  validE_i;
  logic [13:0] opE_i;
  logic [1:0]  mispredictE_i;
  logic [1:0]  predtakenE_i;
  logic [63:0] pcF_i;
  logic [63:0] instrF_i;
  logic [2:0]  sel_i;

  logic [31:0] rdataA;
  logic        haltedA;
  logic        timeoutA;
  logic [1:0]  stateA;
  logic [7:0]  rdataS;
  logic        haltedS;
  logic        timeoutS;
  logic [1:0]  stateS;
  logic [31:0] rdataT;
  logic        haltedT;
  logic        timeoutT;
  logic [1:0]  stateT;

  int nTests;
  int nFailed;

  ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(32), .HALT_CYCLES(2), .MAX_CYCLES(0)) dutA (
    .clk(clk), .reset(reset), .clear_i(clear_i), .enable_i(enable_i),
    .validD_i(validD_i), .instrD_i(instrD_i), .validE_i(validE_i), .opE_i(opE_i),
    .mispredictE_i(mispredictE_i), .predtakenE_i(predtakenE_i),
    .pcF_i(pcF_i), .instrF_i(instrF_i), .sel_i(sel_i),
    .rdata_o(rdataA), .halted_o(haltedA), .timeout_o(timeoutA), .state_o(stateA)
  );

  ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(8), .HALT_CYCLES(2), .MAX_CYCLES(0)) dutS (
    .clk(clk), .reset(reset), .clear_i(clear_i), .enable_i(enable_i),
    .validD_i(validD_i), .instrD_i(instrD_i), .validE_i(validE_i), .opE_i(opE_i),
    .mispredictE_i(mispredictE_i), .predtakenE_i(predtakenE_i),
    .pcF_i(pcF_i), .instrF_i(instrF_i), .sel_i(sel_i),
    .rdata_o(rdataS), .halted_o(haltedS), .timeout_o(timeoutS), .state_o(stateS)
  );

  ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(32), .HALT_CYCLES(2), .MAX_CYCLES(5)) dutT (
    .clk(clk), .reset(reset), .clear_i(clear_i), .enable_i(enable_i),
    .validD_i(validD_i), .instrD_i(instrD_i), .validE_i(validE_i), .opE_i(opE_i),
    .mispredictE_i(mispredictE_i), .predtakenE_i(predtakenE_i),
    .pcF_i(pcF_i), .instrF_i(instrF_i), .sel_i(sel_i),
    .rdata_o(rdataT), .halted_o(haltedT), .timeout_o(timeoutT), .state_o(stateT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nTests++;
    if (observed !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the enable for one cycle with the other inputs as already set.
  task automatic applyStimulus(input logic en);
    enable_i = en;
    step();
  endtask

  task automatic clearInputs();
    clear_i       = 1'b0;
    enable_i      = 1'b0;
    validD_i      = '0;
    instrD_i      = '0;
    validE_i      = '0;
    opE_i         = '0;
    mispredictE_i = '0;
    predtakenE_i  = '0;
    pcF_i         = '0;
    instrF_i      = '0;
    sel_i         = 3'd0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Counting frozen while reading; rdata is valid one edge after sel changes.
  task automatic doRead(input logic [2:0] sel);
    enable_i = 1'b0;
    sel_i    = sel;
    step();
  endtask

  initial begin
    nTests  = 0;
    nFailed = 0;
    reset   = 1'b1;
    clearInputs();

    // Reset state.
    doReset();
    checkOutput("reset rdata", 64'(rdataA), 64'd0);
    checkOutput("reset state", 64'(stateA), 64'd0);
    checkOutput("reset halted", 64'(haltedA), 64'd0);
    checkOutput("reset timeout", 64'(timeoutT), 64'd0);

    // Ten counting cycles of two ADDIs; first edge only leaves IDLE.
    validD_i = 2'b11;
    instrD_i = {ADDI, ADDI};
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(1'b1);
      if (i == 1) checkOutput("idle->run state", 64'(stateA), 64'd1);
      if (i == 5) checkOutput("timeout before cyc5", 64'(timeoutT), 64'd0);
      if (i == 6) checkOutput("timeout at cyc5", 64'(timeoutT), 64'd1);
    end
    doRead(3'd0);
    checkOutput("addi CYC", 64'(rdataA), 64'd10);
    checkOutput("timeout CYC", 64'(rdataT), 64'd5);
    checkOutput("timeout state", 64'(stateT), 64'd3);
    doRead(3'd1);
    checkOutput("addi INS", 64'(rdataA), 64'd20);
    doRead(3'd6);
    checkOutput("addi INS0", 64'(rdataA), 64'd10);
    checkOutput("run state", 64'(stateA), 64'd1);

    // Clear: rdata still samples the pre-clear value on the clearing edge.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checkOutput("clear rdata sampled", 64'(rdataA), 64'd10);
    checkOutput("clear state", 64'(stateT), 64'd0);
    checkOutput("clear timeout", 64'(timeoutT), 64'd0);
    doRead(3'd0);
    checkOutput("clear CYC", 64'(rdataT), 64'd0);
    doRead(3'd1);
    checkOutput("clear INS", 64'(rdataA), 64'd0);

    // Branch/jump accounting over three counting cycles.
    validD_i = '0;
    applyStimulus(1'b1);
    validE_i = 2'b11; opE_i = {OPJ, OPB};  mispredictE_i = 2'b01; predtakenE_i = 2'b00;
    applyStimulus(1'b1);
    validE_i = 2'b11; opE_i = {OPB, OPJR}; mispredictE_i = 2'b00; predtakenE_i = 2'b01;
    applyStimulus(1'b1);
    validE_i = 2'b00; opE_i = {OPB, OPB};  mispredictE_i = 2'b11; predtakenE_i = 2'b00;
    applyStimulus(1'b1);
    validE_i = '0;
    doRead(3'd2);
    checkOutput("BR", 64'(rdataA), 64'd2);
    doRead(3'd3);
    checkOutput("BRM", 64'(rdataA), 64'd1);
    doRead(3'd4);
    checkOutput("JMP", 64'(rdataA), 64'd2);
    doRead(3'd5);
    checkOutput("JMPM", 64'(rdataA), 64'd1);
    doRead(3'd0);
    checkOutput("br CYC", 64'(rdataA), 64'd3);
    doRead(3'd7);
    checkOutput("sel7 zero", 64'(rdataA), 64'd0);

    // Halt detection: NOPs at fixed PCs; halt on the third counted cycle.
    doReset();
    applyStimulus(1'b1);
    instrF_i = {NOPI, NOPI};
    pcF_i    = {32'h0000_0044, 32'h0000_0040};
    applyStimulus(1'b1);
    checkOutput("halt edge1", 64'(haltedA), 64'd0);
    applyStimulus(1'b1);
    checkOutput("halt edge2", 64'(haltedA), 64'd0);
    applyStimulus(1'b1);
    checkOutput("halt edge3", 64'(haltedA), 64'd1);
    checkOutput("halt state", 64'(stateA), 64'd2);
    validD_i = 2'b11;
    instrD_i = {ADDI, ADDI};
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    validD_i = '0;
    doRead(3'd0);
    checkOutput("halt CYC frozen", 64'(rdataA), 64'd3);
    doRead(3'd1);
    checkOutput("halt INS frozen", 64'(rdataA), 64'd0);
    checkOutput("halt sticky", 64'(haltedA), 64'd1);

    // Saturation: 130 cycles of two useful instructions on an 8-bit build.
    doReset();
    validD_i = 2'b11;
    instrD_i = {ADDI, ADDI};
    for (int i = 0; i < 131; i++) applyStimulus(1'b1);
    validD_i = '0;
    doRead(3'd0);
    checkOutput("sat CYC", 64'(rdataS), 64'd130);
    checkOutput("wide CYC", 64'(rdataA), 64'd130);
    doRead(3'd1);
    checkOutput("sat INS", 64'(rdataS), 64'd255);
    checkOutput("wide INS", 64'(rdataA), 64'd260);
    doRead(3'd6);
    checkOutput("sat INS0", 64'(rdataS), 64'd130);

    // Enable toggling with idle fetch: streak restarts, no premature halt.
    doReset();
    validD_i = 2'b11;
    instrD_i = {NOPI, ADDI};
    instrF_i = {NOPI, NOPI};
    pcF_i    = {32'h0000_0044, 32'h0000_0040};
    applyStimulus(1'b1);
    begin
      logic [7:0] pattern;
      pattern = 8'b1010_1011;
      for (int i = 0; i < 8; i++) begin
        applyStimulus(pattern[i]);
        checkOutput($sformatf("toggle nohalt %0d", i), 64'(haltedA), 64'd0);
      end
    end
    checkOutput("toggle state", 64'(stateA), 64'd1);
    doRead(3'd0);
    checkOutput("toggle CYC", 64'(rdataA), 64'd5);
    applyStimulus(1'b1);
    checkOutput("restart streak1", 64'(haltedA), 64'd0);
    applyStimulus(1'b1);
    checkOutput("restart streak2", 64'(haltedA), 64'd1);
    doRead(3'd0);
    checkOutput("toggle CYC final", 64'(rdataA), 64'd7);
    doRead(3'd1);
    checkOutput("toggle INS", 64'(rdataA), 64'd7);
    doRead(3'd6);
    checkOutput("toggle INS0", 64'(rdataA), 64'd7);

    $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
    $finish;
  end

endmodule
